serial_adder_unit: RTL and testbench
====================================

SERIAL_ADDER_UNIT -- requirements
Module: serial_adder_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, operand and result width in bits, legal values 2 and above.
REQ-002 The block SHALL have parameter DIGIT, default 1, bits added per cycle; DIGIT SHALL divide WIDTH exactly.
REQ-003 The block SHALL have port clk, input, 1 bit, the rising-edge clock; the block has one clock.
REQ-004 The block SHALL have port rst, input, 1 bit, a synchronous active-high reset.
REQ-005 The block SHALL have port a, input, WIDTH bits, operand A.
REQ-006 The block SHALL have port b, input, WIDTH bits, operand B.
REQ-007 The block SHALL have port cin, input, 1 bit, the carry-in used when sub=0.
REQ-008 The block SHALL have port sub, input, 1 bit: 0 computes a+b+cin; 1 computes a-b, i.e. a+~b+1, with cin ignored.
REQ-009 The block SHALL have port in_valid, input, 1 bit, which requests an operation.
REQ-010 The block SHALL have port in_ready, output, 1 bit, indicating the block can accept an operation.
REQ-011 The block SHALL have port sum, output, WIDTH bits, the result.
REQ-012 The block SHALL have port carry, output, 1 bit, the final carry-out; for sub=1, carry=1 means no borrow.
REQ-013 The block SHALL have port ovf, output, 1 bit, two's-complement signed overflow.
REQ-014 The block SHALL have port out_valid, output, 1 bit, indicating that sum, carry and ovf are valid.
REQ-015 The block SHALL have port out_ready, input, 1 bit, by which the consumer accepts the result.

Function
REQ-016 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-017 In IDLE, in_ready SHALL be 1; in RUN and DONE, in_ready SHALL be 0.
REQ-018 Accept occurs at a rising edge where in_valid=1 and in_ready=1; on accept, the block SHALL capture a, b (or ~b if sub=1), set the carry to sub ? 1 : cin, clear the digit counter, and go to RUN.
REQ-019 In RUN, each cycle SHALL add the DIGIT low bits of both operand registers plus the carry, shift the DIGIT-bit result into the sum register from the MSB end, shift the operands right by DIGIT, update the carry, and increment the counter.
REQ-020 After WIDTH/DIGIT RUN cycles, the FSM SHALL go to DONE; out_valid SHALL be high starting exactly WIDTH/DIGIT cycles after the accept edge.
REQ-021 carry SHALL equal the carry out of bit WIDTH-1; ovf SHALL equal the carry into bit WIDTH-1 XOR the carry out of bit WIDTH-1, including when the MSB lies inside a multi-bit digit.
REQ-022 sum, carry and ovf SHALL change only on the RUN-to-DONE transition; while in DONE they SHALL hold stable, regardless of how long out_ready stays 0.
REQ-023 At an edge with out_valid=1 and out_ready=1, the FSM SHALL go to IDLE and out_valid SHALL drop; no new operation is accepted on that same edge.
REQ-024 In IDLE, sum, carry and ovf SHALL retain the last result.
REQ-025 in_valid, a, b, cin and sub SHALL be ignored outside of an accept edge; changing them during RUN SHALL NOT affect the result.
REQ-026 Throughput SHALL be one operation per WIDTH/DIGIT+2 cycles when out_ready is held at 1 and in_valid is asserted continuously.
REQ-027 Results SHALL be exact modulo 2^WIDTH for all operands, including wrap-around: all-ones + 1 gives sum=0 and carry=1.

Reset
REQ-028 While rst=1 at a rising edge, the block SHALL enter IDLE with in_ready=1, out_valid=0, sum=0, carry=0, ovf=0, and counter=0.
REQ-029 rst SHALL take priority over every handshake and state transition.
REQ-030 A reset asserted during RUN or DONE SHALL abort the operation; no out_valid pulse SHALL be produced for it.
REQ-031 The first accept SHALL be possible at the first edge after rst deasserts.

Verification
REQ-032 With WIDTH=8 and DIGIT=1, the bench SHALL apply a=0xFF, b=0x01, cin=0, sub=0 -> out_valid 8 cycles after accept, with sum=0x00, carry=1, ovf=0.
REQ-033 With WIDTH=8 and DIGIT=1, the bench SHALL apply a=0x7F, b=0x01, cin=0, sub=0 -> sum=0x80, carry=0, ovf=1.
REQ-034 With WIDTH=8 and DIGIT=1, the bench SHALL apply a=0x05, b=0x07, sub=1, cin=1 -> sum=0xFE, carry=0 (borrow), ovf=0; cin has no effect.
REQ-035 The bench SHALL hold out_ready=0 for 5 cycles in DONE while pulsing in_valid with new operands -> sum, carry and ovf stable, in_ready=0, no accept; then out_ready=1 -> IDLE on the next edge.
REQ-036 The bench SHALL assert rst for one cycle at RUN cycle 3 -> next cycle in_ready=1, out_valid=0, sum=0; a following operation a=0x10, b=0x22 SHALL then give sum=0x32.
REQ-037 With WIDTH=8 and DIGIT=4, the bench SHALL apply a=0x0F, b=0x01, cin=1, sub=0 -> out_valid 2 cycles after accept, with sum=0x11, carry=0, ovf=0.

Source files
------------

// File: rtl/serial_adder_unit.sv
// Digit-serial adder/subtractor: DIGIT bits of a+b+cin (or a-b) are summed per cycle.
// Latency: result valid WIDTH/DIGIT cycles after the accept edge; one op per WIDTH/DIGIT+2 cycles.
// Backpressure: result is held stable in DONE until out_ready; in_ready is low while busy.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   a, b, cin, sub      operands; sub=1 computes a-b (cin ignored), sub=0 computes a+b+cin
//   in_valid/in_ready   operation request handshake
//   sum, carry, ovf     result, carry-out (for subtract: 1 = no borrow), signed overflow
//   out_valid/out_ready result handshake
module serial_adder_unit #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;      // sum being assembled, fills from the MSB end
  logic [WIDTH-1:0] sum_q, sum_d;      // published result, only written on RUN->DONE
  logic             c_q, c_d;          // running carry between digits
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [DIGIT:0]   dsum;
  logic             msb_cin;
  logic             last;

  assign dsum = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, c_q};

  // Carry into the top bit of the current digit, recovered from its sum bit:
  // s = a ^ b ^ cin  =>  cin = s ^ a ^ b. Works for any DIGIT, including 1.
  assign msb_cin = dsum[DIGIT-1] ^ a_q[DIGIT-1] ^ b_q[DIGIT-1];

  assign last = (cnt_q == CW'(NDIG - 1));

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    sum_d       = sum_q;
    c_d         = c_q;
    carry_d     = carry_q;
    ovf_d       = ovf_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    cnt_d       = cnt_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d        = a;
          b_d        = sub ? ~b : b;
          c_d        = sub ? 1'b1 : cin;
          cnt_d      = '0;
          acc_d      = '0;
          in_ready_d = 1'b0;
          state_d    = RUN;
        end
      end
      RUN: begin
        a_d   = a_q >> DIGIT;
        b_d   = b_q >> DIGIT;
        c_d   = dsum[DIGIT];
        acc_d = (acc_q >> DIGIT) | (WIDTH'(dsum[DIGIT-1:0]) << (WIDTH - DIGIT));
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          // The digit just added holds the MSB, so its carries define carry/ovf.
          sum_d       = acc_d;
          carry_d     = dsum[DIGIT];
          ovf_d       = msb_cin ^ dsum[DIGIT];
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      sum_q       <= '0;
      c_q         <= 1'b0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      sum_q       <= sum_d;
      c_q         <= c_d;
      carry_q     <= carry_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      cnt_q       <= cnt_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign carry     = carry_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_adder_unit.sv
// Bench for serial_adder_unit: two instances, WIDTH=8 with DIGIT=1 and DIGIT=4.
// Stimulus pushes expected results into per-instance queues; monitors pop and compare.
// Also covers hold-in-DONE, mid-run reset abort, throughput and reset values.
module tb_serial_adder_unit;

  typedef struct {
    logic [7:0] s;
    logic       c;
    logic       o;
    int         acc;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic       sb;
    logic [7:0] s;
    logic       c;
    logic       o;
  } vec_t;

  logic       clk;
  int         cyc;
  int         n_chk;
  int         n_fail;

  logic       rst_s       [2];
  logic [7:0] a_s         [2];
  logic [7:0] b_s         [2];
  logic       cin_s       [2];
  logic       sub_s       [2];
  logic       in_valid_s  [2];
  logic       in_ready_s  [2];
  logic [7:0] sum_s       [2];
  logic       carry_s     [2];
  logic       ovf_s       [2];
  logic       out_valid_s [2];
  logic       out_ready_s [2];

  exp_t exp_q [2][$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int DG = (g == 0) ? 1 : 4;

    serial_adder_unit #(.WIDTH(8), .DIGIT(DG)) u_dut (
      .clk      (clk),
      .rst      (rst_s[g]),
      .a        (a_s[g]),
      .b        (b_s[g]),
      .cin      (cin_s[g]),
      .sub      (sub_s[g]),
      .in_valid (in_valid_s[g]),
      .in_ready (in_ready_s[g]),
      .sum      (sum_s[g]),
      .carry    (carry_s[g]),
      .ovf      (ovf_s[g]),
      .out_valid(out_valid_s[g]),
      .out_ready(out_ready_s[g])
    );

    int         first_cyc;
    logic       prev_vld;
    logic [7:0] hs;
    logic       hc;
    logic       ho;
    exp_t       e;

    initial prev_vld = 1'b0;

    always @(negedge clk) begin
      if (out_valid_s[g] === 1'b1) begin
        if (prev_vld !== 1'b1) begin
          first_cyc = cyc;
          hs = sum_s[g];
          hc = carry_s[g];
          ho = ovf_s[g];
        end else begin
          chk($sformatf("dut%0d hold sum", g), {24'd0, sum_s[g]}, {24'd0, hs});
          chk($sformatf("dut%0d hold carry/ovf", g), {30'd0, carry_s[g], ovf_s[g]}, {30'd0, hc, ho});
        end
        if (out_ready_s[g] === 1'b1) begin
          if (exp_q[g].size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL dut%0d unexpected result: got sum %0h, expected no output", g, sum_s[g]);
          end else begin
            e = exp_q[g].pop_front();
            chk($sformatf("dut%0d sum", g), {24'd0, sum_s[g]}, {24'd0, e.s});
            chk($sformatf("dut%0d carry", g), {31'd0, carry_s[g]}, {31'd0, e.c});
            chk($sformatf("dut%0d ovf", g), {31'd0, ovf_s[g]}, {31'd0, e.o});
            chk($sformatf("dut%0d latency", g), first_cyc - e.acc, 8 / DG);
          end
        end
      end
      prev_vld = out_valid_s[g];
    end
  end

  // Drives one operation; returns just after the edge following accept, with
  // the inputs scrambled so that a design sampling them during RUN is caught.
  task automatic issue(input int d, input bit nowait, input logic [7:0] av, input logic [7:0] bv,
                       input logic ci, input logic sb, input bit push,
                       input logic [7:0] es, input logic ec, input logic eo);
    int waited;
    exp_t x;
    waited = 0;
    if (!nowait) begin
      @(posedge clk); #1;
    end
    a_s[d] = av; b_s[d] = bv; cin_s[d] = ci; sub_s[d] = sb; in_valid_s[d] = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready_s[d] === 1'b1) break;
      waited++;
      if (waited > 100) begin
        n_chk++;
        n_fail++;
        $display("FAIL dut%0d accept timeout: got in_ready %b, expected 1", d, in_ready_s[d]);
        in_valid_s[d] = 1'b0;
        return;
      end
    end
    if (push) begin
      x.s = es; x.c = ec; x.o = eo; x.acc = cyc + 1;
      exp_q[d].push_back(x);
    end
    @(posedge clk); #1;
    in_valid_s[d] = 1'b0;
    a_s[d] = ~av; b_s[d] = 8'h5A; cin_s[d] = ~ci; sub_s[d] = ~sb;
  endtask

  task automatic wait_idle(input int d);
    int n;
    n = 0;
    while ((exp_q[d].size() != 0 || in_ready_s[d] !== 1'b1) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      n_chk++;
      n_fail++;
      $display("FAIL dut%0d drain timeout: got %0d pending, expected 0", d, exp_q[d].size());
    end
  endtask

  vec_t vt [6];
  int   accs [2];
  int   na;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0;
    n_fail = 0;
    for (int d = 0; d < 2; d++) begin
      rst_s[d] = 1'b1; a_s[d] = '0; b_s[d] = '0; cin_s[d] = 1'b0; sub_s[d] = 1'b0;
      in_valid_s[d] = 1'b0; out_ready_s[d] = 1'b1;
    end

    vt[0] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
    vt[1] = '{8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0};
    vt[2] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
    vt[3] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
    vt[4] = '{8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 1'b0, 1'b0};
    vt[5] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};

    // Reset values; operation already requested while in reset.
    a_s[0] = 8'hFF; b_s[0] = 8'h01; in_valid_s[0] = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("dut%0d reset in_ready", d), {31'd0, in_ready_s[d]}, 32'd1);
      chk($sformatf("dut%0d reset out_valid", d), {31'd0, out_valid_s[d]}, 32'd0);
      chk($sformatf("dut%0d reset sum", d), {24'd0, sum_s[d]}, 32'd0);
      chk($sformatf("dut%0d reset carry/ovf", d), {30'd0, carry_s[d], ovf_s[d]}, 32'd0);
    end
    @(posedge clk); #1;
    rst_s[0] = 1'b0; rst_s[1] = 1'b0;
    // First edge after reset release must accept.
    issue(0, 1'b1, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
    wait_idle(0);

    for (int i = 0; i < 5; i++) begin
      issue(0, 1'b0, vt[i].a, vt[i].b, vt[i].ci, vt[i].sb, 1'b1, vt[i].s, vt[i].c, vt[i].o);
      wait_idle(0);
    end

    // Hold result in DONE while new requests are presented.
    out_ready_s[0] = 1'b0;
    issue(0, 1'b0, 8'h33, 8'h11, 1'b0, 1'b0, 1'b1, 8'h44, 1'b0, 1'b0);
    na = 0;
    while (out_valid_s[0] !== 1'b1 && na < 20) begin
      @(negedge clk);
      na++;
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      in_valid_s[0] = 1'b1; a_s[0] = 8'(i * 37); b_s[0] = 8'(i + 9); sub_s[0] = i[0];
      @(negedge clk);
      chk("dut0 done in_ready", {31'd0, in_ready_s[0]}, 32'd0);
      chk("dut0 done out_valid", {31'd0, out_valid_s[0]}, 32'd1);
    end
    @(posedge clk); #1;
    out_ready_s[0] = 1'b1;
    @(posedge clk); #1;
    in_valid_s[0] = 1'b0;
    @(negedge clk);
    chk("dut0 after release in_ready", {31'd0, in_ready_s[0]}, 32'd1);
    chk("dut0 after release out_valid", {31'd0, out_valid_s[0]}, 32'd0);
    chk("dut0 idle keeps sum", {24'd0, sum_s[0]}, 32'h44);

    // Reset mid-run aborts the operation.
    issue(0, 1'b0, 8'h55, 8'h0A, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_s[0] = 1'b1;
    @(posedge clk); #1;
    rst_s[0] = 1'b0;
    @(negedge clk);
    chk("dut0 abort in_ready", {31'd0, in_ready_s[0]}, 32'd1);
    chk("dut0 abort out_valid", {31'd0, out_valid_s[0]}, 32'd0);
    chk("dut0 abort sum", {24'd0, sum_s[0]}, 32'd0);
    repeat (12) @(negedge clk);
    issue(0, 1'b0, 8'h10, 8'h22, 1'b0, 1'b0, 1'b1, 8'h32, 1'b0, 1'b0);
    wait_idle(0);

    // Throughput with in_valid held high.
    @(posedge clk); #1;
    a_s[0] = 8'h21; b_s[0] = 8'h43; cin_s[0] = 1'b0; sub_s[0] = 1'b0; in_valid_s[0] = 1'b1;
    na = 0; accs[0] = 0; accs[1] = 0;
    for (int i = 0; i < 40 && na < 2; i++) begin
      @(negedge clk);
      if (in_ready_s[0] === 1'b1) begin
        accs[na] = cyc + 1;
        exp_q[0].push_back('{8'h64, 1'b0, 1'b0, cyc + 1});
        na++;
        if (na == 2) begin
          @(posedge clk); #1;
          in_valid_s[0] = 1'b0;
        end
      end
    end
    in_valid_s[0] = 1'b0;
    chk("dut0 accepts seen", na, 32'd2);
    chk("dut0 throughput", accs[1] - accs[0], 32'd10);
    wait_idle(0);

    // DIGIT=4 instance.
    issue(1, 1'b0, 8'h0F, 8'h01, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0);
    wait_idle(1);
    for (int i = 0; i < 6; i++) begin
      issue(1, 1'b0, vt[i].a, vt[i].b, vt[i].ci, vt[i].sb, 1'b1, vt[i].s, vt[i].c, vt[i].o);
      wait_idle(1);
    end

    repeat (20) @(negedge clk);
    chk("dut0 queue empty", exp_q[0].size(), 32'd0);
    chk("dut1 queue empty", exp_q[1].size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
